ee_prog_req: RTL and testbench

Request-side controller for the EEPROM programming handshake. It collects write frames decoded by the SPI slave into a page latch. At frame end it raises `ee_wbusy_s` to start the high-voltage programming timer, holds the latched page stable for the whole cycle, and releases on the timer's `ee_wdone`. It sits between the SPI command decoder and the programming timer, and owns the busy/WIP status seen by the host.

---
 rtl/ee_prog_pkg.sv | 32 +++
 rtl/ee_page_buf.sv | 95 +++++++++
 rtl/ee_prog_req.sv | 225 ++++++++++++++++++++++
 tb/tb_ee_prog_req.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ee_prog_pkg.sv
// ---------------------------------------------------------------------------
// ee_prog_pkg
// Shared definitions for the EEPROM programming request controller:
//   - FSM state encoding of ee_prog_req
//   - default page depth, address width and watchdog limit
//   - page/byte write mode constants (value of wr_cmd_page)
//   - ee_col_w(): column pointer width for a given page depth (min. 1 bit)
// ---------------------------------------------------------------------------
package ee_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_BUSY = 3'd3,
        ST_DONE = 3'd4
    } ee_state_t;

    localparam int EE_PAGE_BYTES = 16;
    localparam int EE_ADDR_W     = 12;
    localparam int EE_TMO_CYC    = 4096;

    localparam logic EE_MODE_PAGE = 1'b1;
    localparam logic EE_MODE_BYTE = 1'b0;

    // A single-byte page still needs a 1-bit pointer so the port is legal;
    // that pointer is held at 0 by the modulo increment.
    function automatic int ee_col_w(input int page_bytes);
        return (page_bytes > 1) ? $clog2(page_bytes) : 1;
    endfunction

endpackage

// File: rtl/ee_page_buf.sv
// ---------------------------------------------------------------------------
// ee_page_buf
// Page latch for the EEPROM programming path: PAGE_BYTES data bytes plus a
// byte-valid mask, a wrapping column pointer and the timer-driven clears.
//
// Ports
//   sys_clk, sys_rst   clock, asynchronous active-high reset
//   load               start of a new command: pointer <- load_col, mask <- 0
//   load_col           start column of the new command
//   wr_en              write wr_byte at the pointer, then advance the pointer
//   wr_byte            data byte
//   dact_clr           clear the mask (wins over a coincident write)
//   data_clr           clear the data bytes (wins over a coincident write)
//   flush              clear mask and data (empty frame discarded)
//   pg_data            registered page, byte i at [8i+7:8i]
//   pg_mask            registered byte-valid mask
//   mask_upd           mask as it will be after this cycle's write/clears,
//                      excluding load/flush; lets the FSM judge a frame end
//                      that coincides with its last data byte
// ---------------------------------------------------------------------------
module ee_page_buf
    import ee_prog_pkg::*;
#(
    parameter  int PAGE_BYTES = EE_PAGE_BYTES,
    localparam int COL_W      = ee_col_w(PAGE_BYTES)
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    load,
    input  logic [COL_W-1:0]        load_col,
    input  logic                    wr_en,
    input  logic [7:0]              wr_byte,
    input  logic                    dact_clr,
    input  logic                    data_clr,
    input  logic                    flush,
    output logic [8*PAGE_BYTES-1:0] pg_data,
    output logic [PAGE_BYTES-1:0]   pg_mask,
    output logic [PAGE_BYTES-1:0]   mask_upd
);

    logic [COL_W-1:0]      col_reg;
    logic [COL_W-1:0]      col_next;
    logic [PAGE_BYTES-1:0] mask_reg;
    logic [PAGE_BYTES-1:0] col_hot;
    logic                  wr_ok;

    // Either timer clear suppresses the byte and its mask bit entirely.
    assign wr_ok = wr_en && !dact_clr && !data_clr;

    // Modulo-PAGE_BYTES increment; also correct for non-full pointer ranges.
    assign col_next = (col_reg == COL_W'(PAGE_BYTES - 1)) ? '0 : col_reg + 1'b1;

    assign mask_upd = dact_clr ? '0 : (mask_reg | (wr_ok ? col_hot : '0));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col_reg  <= '0;
            mask_reg <= '0;
        end else begin
            if (load) begin
                col_reg <= load_col;
            end else if (wr_en) begin
                col_reg <= col_next;
            end
            if (load || flush) begin
                mask_reg <= '0;
            end else begin
                mask_reg <= mask_upd;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < PAGE_BYTES; gi++) begin : g_byte
            logic [7:0] byte_reg;

            assign col_hot[gi] = (col_reg == COL_W'(gi));

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    byte_reg <= '0;
                end else if (flush || data_clr) begin
                    byte_reg <= '0;
                end else if (wr_ok && col_hot[gi]) begin
                    byte_reg <= wr_byte;
                end
            end

            assign pg_data[8*gi +: 8] = byte_reg;
        end
    endgenerate

    assign pg_mask = mask_reg;

endmodule

// File: rtl/ee_prog_req.sv
// ---------------------------------------------------------------------------
// ee_prog_req
// Request-side controller of the EEPROM programming handshake. Collects the
// write frame from the SPI command decoder into a page latch, raises
// ee_wbusy_s towards the high-voltage programming timer at frame end, keeps
// the page frozen while the timer runs and releases on ee_wdone.
//
// Optional feature: define EE_PROG_TIMEOUT_EN to add a BUSY watchdog that
// abandons the request after TMO_CYC cycles without ee_wdone.
//
// Ports
//   sys_clk, sys_rst  clock, asynchronous active-high reset
//   wr_cmd_vld        write command decoded (pulse), qualified by wr_cmd_page
//   wr_cmd_page       1 = page write, 0 = byte write
//   wr_addr           start byte address
//   wr_data_vld       data byte received (pulse), byte on wr_data
//   wr_frm_end        host ended the frame (pulse)
//   ee_wdone          programming finished (pulse from the timer)
//   spi_dact_clr      timer pulse: clear byte-valid mask
//   spi_data_clr      timer pulse: clear data bytes
//   ee_wbusy_s        programming request level to the timer
//   ee_pg_addr        page base address (column bits 0)
//   ee_pg_data        latched page, byte i at [8i+7:8i]
//   ee_pg_mask        byte-valid mask
//   ee_wip            write-in-progress status (ARM, BUSY, DONE)
//   wr_rej            command/data byte rejected (pulse)
//   ee_err            sticky error, cleared by reset only
// All outputs are registered.
// ---------------------------------------------------------------------------
module ee_prog_req
    import ee_prog_pkg::*;
#(
    parameter int PAGE_BYTES = EE_PAGE_BYTES,
    parameter int ADDR_W     = EE_ADDR_W,
    parameter int TMO_CYC    = EE_TMO_CYC
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    wr_cmd_vld,
    input  logic                    wr_cmd_page,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic                    wr_data_vld,
    input  logic [7:0]              wr_data,
    input  logic                    wr_frm_end,
    input  logic                    ee_wdone,
    input  logic                    spi_dact_clr,
    input  logic                    spi_data_clr,
    output logic                    ee_wbusy_s,
    output logic [ADDR_W-1:0]       ee_pg_addr,
    output logic [8*PAGE_BYTES-1:0] ee_pg_data,
    output logic [PAGE_BYTES-1:0]   ee_pg_mask,
    output logic                    ee_wip,
    output logic                    wr_rej,
    output logic                    ee_err
);

    localparam int                COL_W    = ee_col_w(PAGE_BYTES);
    localparam logic [ADDR_W-1:0] COL_MASK = ADDR_W'(PAGE_BYTES - 1);

    ee_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] pg_addr_reg, pg_addr_next;
    logic              mode_reg, mode_next;
    logic              taken_reg, taken_next;     // byte mode: first byte already stored
    logic              wbusy_reg, wbusy_next;
    logic              wip_reg, wip_next;
    logic              rej_reg, rej_next;
    logic              err_reg, err_next;

    logic                  buf_load;
    logic                  buf_flush;
    logic                  buf_wr_en;
    logic                  byte_drop;
    logic                  hv_active;
    logic                  tmo_hit;
    logic [COL_W-1:0]      load_col;
    logic [PAGE_BYTES-1:0] mask_upd;

    assign load_col  = COL_W'(wr_addr) & COL_W'(PAGE_BYTES - 1);
    assign hv_active = (state_reg == ST_ARM) || (state_reg == ST_BUSY) || (state_reg == ST_DONE);

    // A command in the same cycle as a data byte restarts LOAD; the byte
    // belongs to the abandoned frame and is dropped silently.
    assign buf_wr_en = (state_reg == ST_LOAD) && wr_data_vld && !wr_cmd_vld &&
                       ((mode_reg == EE_MODE_PAGE) || !taken_reg);
    assign byte_drop = (state_reg == ST_LOAD) && wr_data_vld && !wr_cmd_vld &&
                       (mode_reg == EE_MODE_BYTE) && taken_reg;

`ifdef EE_PROG_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;

    // Counts BUSY cycles; leaves BUSY on the TMO_CYC-th one, so no wrap.
    assign tmo_cnt_next = (state_reg == ST_BUSY) ? tmo_cnt_reg + 1'b1 : '0;
    assign tmo_hit      = (state_reg == ST_BUSY) && (tmo_cnt_reg == CNT_W'(TMO_CYC - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end
`else
    logic tmo_unused;

    assign tmo_hit    = 1'b0;
    assign tmo_unused = (TMO_CYC != 0);
`endif

    always_comb begin
        state_next   = state_reg;
        pg_addr_next = pg_addr_reg;
        mode_next    = mode_reg;
        taken_next   = taken_reg;
        err_next     = err_reg;
        rej_next     = 1'b0;
        buf_load     = 1'b0;
        buf_flush    = 1'b0;

        case (state_reg)
            ST_IDLE, ST_LOAD: begin
                if (wr_cmd_vld) begin
                    // New command (or restart): new page, empty mask.
                    state_next   = ST_LOAD;
                    pg_addr_next = wr_addr & ~COL_MASK;
                    mode_next    = wr_cmd_page ? EE_MODE_PAGE : EE_MODE_BYTE;
                    taken_next   = 1'b0;
                    buf_load     = 1'b1;
                end else if (state_reg == ST_LOAD) begin
                    if (buf_wr_en) begin
                        taken_next = 1'b1;
                    end
                    if (byte_drop) begin
                        rej_next = 1'b1;
                        err_next = 1'b1;
                    end
                    if (wr_frm_end) begin
                        // mask_upd already includes a same-cycle byte.
                        if (|mask_upd) begin
                            state_next = ST_ARM;
                        end else begin
                            state_next = ST_IDLE;
                            buf_flush  = 1'b1;
                        end
                    end
                end
            end
            ST_ARM: begin
                state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (ee_wdone) begin
                    state_next = ST_DONE;
                end else if (tmo_hit) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (hv_active && (wr_cmd_vld || wr_data_vld)) begin
            rej_next = 1'b1;
            err_next = 1'b1;
        end

        // Status flags follow the next state so they are registered yet
        // aligned with the state they describe.
        wbusy_next = (state_next == ST_ARM) || (state_next == ST_BUSY);
        wip_next   = (state_next == ST_ARM) || (state_next == ST_BUSY) ||
                     (state_next == ST_DONE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg   <= ST_IDLE;
            pg_addr_reg <= '0;
            mode_reg    <= EE_MODE_BYTE;
            taken_reg   <= 1'b0;
            wbusy_reg   <= 1'b0;
            wip_reg     <= 1'b0;
            rej_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pg_addr_reg <= pg_addr_next;
            mode_reg    <= mode_next;
            taken_reg   <= taken_next;
            wbusy_reg   <= wbusy_next;
            wip_reg     <= wip_next;
            rej_reg     <= rej_next;
            err_reg     <= err_next;
        end
    end

    ee_page_buf #(
        .PAGE_BYTES (PAGE_BYTES)
    ) u_page_buf (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (buf_load),
        .load_col (load_col),
        .wr_en    (buf_wr_en),
        .wr_byte  (wr_data),
        .dact_clr (spi_dact_clr),
        .data_clr (spi_data_clr),
        .flush    (buf_flush),
        .pg_data  (ee_pg_data),
        .pg_mask  (ee_pg_mask),
        .mask_upd (mask_upd)
    );

    assign ee_wbusy_s = wbusy_reg;
    assign ee_pg_addr = pg_addr_reg;
    assign ee_wip     = wip_reg;
    assign wr_rej     = rej_reg;
    assign ee_err     = err_reg;

endmodule

// File: tb/tb_ee_prog_req.sv
// ---------------------------------------------------------------------------
// tb_ee_prog_req
// Directed bench for ee_prog_req (PAGE_BYTES=16, ADDR_W=12, TMO_CYC=64).
// Inputs change 1 ns after the rising edge; outputs are compared there too.
// ---------------------------------------------------------------------------
module tb_ee_prog_req;

    logic         sys_clk;
    logic         sys_rst;
    logic         wr_cmd_vld;
    logic         wr_cmd_page;
    logic [11:0]  wr_addr;
    logic         wr_data_vld;
    logic [7:0]   wr_data;
    logic         wr_frm_end;
    logic         ee_wdone;
    logic         spi_dact_clr;
    logic         spi_data_clr;
    logic         ee_wbusy_s;
    logic [11:0]  ee_pg_addr;
    logic [127:0] ee_pg_data;
    logic [15:0]  ee_pg_mask;
    logic         ee_wip;
    logic         wr_rej;
    logic         ee_err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [127:0] exp_pg;

    ee_prog_req #(
        .PAGE_BYTES (16),
        .ADDR_W     (12),
        .TMO_CYC    (64)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .wr_cmd_vld   (wr_cmd_vld),
        .wr_cmd_page  (wr_cmd_page),
        .wr_addr      (wr_addr),
        .wr_data_vld  (wr_data_vld),
        .wr_data      (wr_data),
        .wr_frm_end   (wr_frm_end),
        .ee_wdone     (ee_wdone),
        .spi_dact_clr (spi_dact_clr),
        .spi_data_clr (spi_data_clr),
        .ee_wbusy_s   (ee_wbusy_s),
        .ee_pg_addr   (ee_pg_addr),
        .ee_pg_data   (ee_pg_data),
        .ee_pg_mask   (ee_pg_mask),
        .ee_wip       (ee_wip),
        .wr_rej       (wr_rej),
        .ee_err       (ee_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %-14s got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %-14s %0h", tag, obs);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [11:0] addr, input logic page);
        wr_cmd_vld  = 1'b1;
        wr_cmd_page = page;
        wr_addr     = addr;
        cyc();
        wr_cmd_vld  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        wr_data_vld = 1'b1;
        wr_data     = d;
        cyc();
        wr_data_vld = 1'b0;
    endtask

    task automatic frame_end();
        wr_frm_end = 1'b1;
        cyc();
        wr_frm_end = 1'b0;
    endtask

    task automatic wdone_pulse();
        ee_wdone = 1'b1;
        cyc();
        ee_wdone = 1'b0;
    endtask

    initial begin
        sys_rst      = 1'b1;
        wr_cmd_vld   = 1'b0;
        wr_cmd_page  = 1'b0;
        wr_addr      = '0;
        wr_data_vld  = 1'b0;
        wr_data      = '0;
        wr_frm_end   = 1'b0;
        ee_wdone     = 1'b0;
        spi_dact_clr = 1'b0;
        spi_data_clr = 1'b0;

        // Reset state
        repeat (3) cyc();
        check("rst_wbusy", 128'(ee_wbusy_s), 128'(0));
        check("rst_addr",  128'(ee_pg_addr), 128'(0));
        check("rst_data",  ee_pg_data,       128'(0));
        check("rst_mask",  128'(ee_pg_mask), 128'(0));
        check("rst_flags", 128'({ee_wip, wr_rej, ee_err}), 128'(0));
        sys_rst = 1'b0;
        cyc();

        // Page write at 0x123, bytes A0..A3 -> columns 3..6
        send_cmd(12'h123, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        check("t1_load_busy", 128'(ee_wbusy_s), 128'(0));
        frame_end();
        exp_pg = '0;
        for (int i = 0; i < 4; i++) exp_pg[8*(3+i) +: 8] = 8'hA0 + 8'(i);
        check("t1_arm_busy", 128'(ee_wbusy_s), 128'(1));
        check("t1_arm_wip",  128'(ee_wip),     128'(1));
        check("t1_addr",     128'(ee_pg_addr), 128'(12'h120));
        check("t1_mask",     128'(ee_pg_mask), 128'(16'h0078));
        check("t1_data",     ee_pg_data,       exp_pg);
        repeat (5) cyc();
        check("t1_hold_busy", 128'(ee_wbusy_s), 128'(1));
        wdone_pulse();
        check("t1_done_busy", 128'(ee_wbusy_s), 128'(0));
        check("t1_done_wip",  128'(ee_wip),     128'(1));
        cyc();
        check("t1_idle_wip",  128'(ee_wip),     128'(0));
        check("t1_err",       128'(ee_err),     128'(0));

        // Byte write at 0x005, bytes 11, 22: second byte rejected
        send_cmd(12'h005, 1'b0);
        send_byte(8'h11);
        check("t2_rej_first", 128'(wr_rej), 128'(0));
        send_byte(8'h22);
        check("t2_rej",       128'(wr_rej), 128'(1));
        check("t2_err",       128'(ee_err), 128'(1));
        cyc();
        check("t2_rej_end",   128'(wr_rej), 128'(0));
        check("t2_mask",      128'(ee_pg_mask), 128'(16'h0020));
        check("t2_byte5",     128'(ee_pg_data[47:40]), 128'(8'h11));
        frame_end();
        check("t2_arm_busy",  128'(ee_wbusy_s), 128'(1));
        cyc();
        wdone_pulse();
        cyc();
        check("t2_idle_wip",  128'(ee_wip), 128'(0));

        // Timer clears in IDLE wipe mask and data
        spi_dact_clr = 1'b1;
        spi_data_clr = 1'b1;
        cyc();
        spi_dact_clr = 1'b0;
        spi_data_clr = 1'b0;
        check("clr_mask", 128'(ee_pg_mask), 128'(0));
        check("clr_data", ee_pg_data,       128'(0));

        // 18-byte page write from column 14; last byte with frame end
        send_cmd(12'h04E, 1'b1);
        for (int k = 1; k <= 17; k++) send_byte(8'h30 + 8'(k));
        wr_data_vld = 1'b1;
        wr_data     = 8'h42;
        wr_frm_end  = 1'b1;
        cyc();
        wr_data_vld = 1'b0;
        wr_frm_end  = 1'b0;
        check("t3_arm_busy", 128'(ee_wbusy_s), 128'(1));
        check("t3_addr",     128'(ee_pg_addr), 128'(12'h040));
        check("t3_mask",     128'(ee_pg_mask), 128'(16'hFFFF));
        check("t3_byte14",   128'(ee_pg_data[8*14 +: 8]), 128'(8'h41));
        check("t3_byte15",   128'(ee_pg_data[8*15 +: 8]), 128'(8'h42));
        check("t3_byte0",    128'(ee_pg_data[7:0]),       128'(8'h33));
        check("t3_byte13",   128'(ee_pg_data[8*13 +: 8]), 128'(8'h40));
        cyc();

        // Command and data during BUSY: rejected, page frozen
        send_cmd(12'h300, 1'b1);
        check("t4_cmd_rej",  128'(wr_rej),     128'(1));
        check("t4_addr",     128'(ee_pg_addr), 128'(12'h040));
        send_byte(8'h99);
        check("t4_data_rej", 128'(wr_rej),     128'(1));
        check("t4_mask",     128'(ee_pg_mask), 128'(16'hFFFF));
        check("t4_byte0",    128'(ee_pg_data[7:0]), 128'(8'h33));
        check("t4_busy",     128'(ee_wbusy_s), 128'(1));
        wdone_pulse();
        check("t4_done_busy", 128'(ee_wbusy_s), 128'(0));
        cyc();
        check("t4_idle_wip",  128'(ee_wip), 128'(0));

        // Clear coinciding with a write wins; empty frame end is dropped
        send_cmd(12'h000, 1'b1);
        wr_data_vld  = 1'b1;
        wr_data      = 8'h55;
        spi_dact_clr = 1'b1;
        cyc();
        wr_data_vld  = 1'b0;
        spi_dact_clr = 1'b0;
        check("t5_clr_mask", 128'(ee_pg_mask), 128'(0));
        frame_end();
        check("t5_busy",     128'(ee_wbusy_s), 128'(0));
        check("t5_flush",    ee_pg_data,       128'(0));

        // Frame end with no data: never leaves for ARM
        send_cmd(12'h200, 1'b1);
        frame_end();
        check("t6_busy",     128'(ee_wbusy_s), 128'(0));
        cyc();
        check("t6_busy2",    128'(ee_wbusy_s), 128'(0));
        check("t6_wip",      128'(ee_wip),     128'(0));

        // Stray ee_wdone in IDLE is ignored
        wdone_pulse();
        check("t7_wip",      128'(ee_wip),     128'(0));

        // Reset mid-BUSY clears outputs without a clock edge
        send_cmd(12'h010, 1'b1);
        send_byte(8'h77);
        frame_end();
        cyc();
        check("t8_busy",     128'(ee_wbusy_s), 128'(1));
        #2;
        sys_rst = 1'b1;
        #1;
        check("t8_rst_busy", 128'(ee_wbusy_s), 128'(0));
        check("t8_rst_addr", 128'(ee_pg_addr), 128'(0));
        check("t8_rst_data", ee_pg_data,       128'(0));
        check("t8_rst_mask", 128'(ee_pg_mask), 128'(0));
        check("t8_rst_flag", 128'({ee_wip, wr_rej, ee_err}), 128'(0));
        cyc();
        sys_rst = 1'b0;
        cyc();

`ifdef EE_PROG_TIMEOUT_EN
        // Watchdog: no ee_wdone, request dropped after 64 BUSY cycles
        send_cmd(12'h020, 1'b1);
        send_byte(8'h5A);
        frame_end();
        repeat (64) cyc();
        check("tmo_still",   128'(ee_wbusy_s), 128'(1));
        cyc();
        check("tmo_busy",    128'(ee_wbusy_s), 128'(0));
        check("tmo_err",     128'(ee_err),     128'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
